// File: rtl/mcpu_avl_arb.sv
// Two-master round-robin arbiter in front of the 128-bit Avalon-MM DDR controller port.
// Write bursts lock the grant; an in-order tag FIFO routes returning read beats to their issuer.
module mcpu_avl_arb #(
  parameter  int ADDR_W   = 25,
  parameter  int DATA_W   = 128,
  parameter  int SIZE_W   = 5,
  parameter  int RD_DEPTH = 8,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clkrst_mem_clk,
  input  logic              clkrst_mem_rst_n,
  // master 0: last-level cache
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_be,
  input  logic              m0_burstbegin,
  input  logic              m0_read_req,
  input  logic              m0_write_req,
  input  logic [SIZE_W-1:0] m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rdata_valid,
  // master 1: secondary client (preload / DMA)
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_be,
  input  logic              m1_burstbegin,
  input  logic              m1_read_req,
  input  logic              m1_write_req,
  input  logic [SIZE_W-1:0] m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rdata_valid,
  // memory controller
  output logic [ADDR_W-1:0] avl_addr,
  output logic [BE_W-1:0]   avl_be,
  output logic              avl_burstbegin,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [SIZE_W-1:0] avl_size,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic              avl_ready,
  input  logic [DATA_W-1:0] avl_rdata,
  input  logic              avl_rdata_valid,
  output logic              rd_err
);

  localparam int                 PTR_W    = $clog2(RD_DEPTH);
  localparam int                 CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(RD_DEPTH);
  localparam logic [SIZE_W-1:0]  ONE_BEAT = SIZE_W'(1);

  typedef enum logic [0:0] {S_IDLE, S_WBURST} state_e;

  logic [ADDR_W-1:0] m_addr  [2];
  logic [BE_W-1:0]   m_be    [2];
  logic [SIZE_W-1:0] m_size  [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic [1:0]        m_bb, rd_req, wr_req, req;

  assign m_addr[0]  = m0_addr;   assign m_addr[1]  = m1_addr;
  assign m_be[0]    = m0_be;     assign m_be[1]    = m1_be;
  assign m_size[0]  = m0_size;   assign m_size[1]  = m1_size;
  assign m_wdata[0] = m0_wdata;  assign m_wdata[1] = m1_wdata;
  assign m_bb   = {m1_burstbegin, m0_burstbegin};
  assign rd_req = {m1_read_req, m0_read_req};
  assign wr_req = {m1_write_req, m0_write_req};
  assign req    = rd_req | wr_req;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [SIZE_W-1:0] beats_left_q, beats_left_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SIZE_W-1:0] head_rcv_q, head_rcv_d;
  logic              rd_err_q, rd_err_d;

  logic              fifo_id_q   [RD_DEPTH];
  logic [SIZE_W-1:0] fifo_size_q [RD_DEPTH];

  logic              gnt_vld, gnt_id, sel_wr, sel_rd, accept;
  logic              fifo_full, fifo_empty, push, pop, rbeat, head_id;
  logic [SIZE_W-1:0] head_size, push_size;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == S_WBURST) begin
      gnt_vld = 1'b1;
      gnt_id  = owner_q;
    end else if (&req) begin
      gnt_vld = 1'b1;
      gnt_id  = prio_q;
    end else if (|req) begin
      gnt_vld = 1'b1;
      gnt_id  = req[1];
    end
  end

  always_comb begin
    avl_addr       = '0;
    avl_be         = '0;
    avl_burstbegin = 1'b0;
    avl_size       = '0;
    avl_wdata      = '0;
    // A read asking alongside a write is not forwarded; a burst owner's reads wait for IDLE.
    sel_wr = gnt_vld & wr_req[gnt_id];
    sel_rd = gnt_vld & (state_q == S_IDLE) & rd_req[gnt_id] & ~wr_req[gnt_id];
    if (sel_wr | sel_rd) begin
      avl_addr       = m_addr[gnt_id];
      avl_be         = m_be[gnt_id];
      avl_burstbegin = m_bb[gnt_id];
      avl_size       = m_size[gnt_id];
      avl_wdata      = m_wdata[gnt_id];
    end
    avl_write_req = sel_wr;
    avl_read_req  = sel_rd & ~fifo_full;
  end

  assign accept   = avl_ready & (avl_write_req | avl_read_req);
  assign m0_ready = accept & ~gnt_id;
  assign m1_ready = accept & gnt_id;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          if (accept) begin
            prio_d = ~gnt_id;
            if (avl_write_req && (m_size[gnt_id] > ONE_BEAT)) begin
              state_d      = S_WBURST;
              owner_d      = gnt_id;
              beats_left_d = m_size[gnt_id] - ONE_BEAT;
            end
          end else begin
            // Pin a stalled grant so the other master cannot swap the command under the controller.
            prio_d = gnt_id;
          end
        end
      end
      S_WBURST: begin
        if (accept) begin
          beats_left_d = beats_left_q - ONE_BEAT;
          if (beats_left_q == ONE_BEAT) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign head_id   = fifo_id_q[rd_ptr_q];
  assign head_size = fifo_size_q[rd_ptr_q];
  assign push      = avl_read_req & avl_ready;
  assign push_size = (m_size[gnt_id] == '0) ? ONE_BEAT : m_size[gnt_id];
  assign rbeat     = avl_rdata_valid & ~fifo_empty;
  assign pop       = rbeat & ((head_rcv_q + ONE_BEAT) == head_size);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q;
    head_rcv_d = head_rcv_q;
    rd_err_d   = rd_err_q | (avl_rdata_valid & fifo_empty);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (rbeat) head_rcv_d = pop ? '0 : head_rcv_q + ONE_BEAT;
  end

  assign m0_rdata       = avl_rdata;
  assign m1_rdata       = avl_rdata;
  assign m0_rdata_valid = rbeat & ~head_id;
  assign m1_rdata_valid = rbeat & head_id;
  assign rd_err         = rd_err_q;

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_rcv_q   <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_rcv_q   <= head_rcv_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // NOTE: tag storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clkrst_mem_clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= gnt_id;
      fifo_size_q[wr_ptr_q] <= push_size;
    end
  end

endmodule

// File: tb/tb_mcpu_avl_arb.sv
// Self-checking bench for mcpu_avl_arb: read routing is scored against a queue of expected
// issuers filled as reads are driven and drained as the controller returns beats.
module tb_mcpu_avl_arb;

  logic          clk, rst_n;
  logic [24:0]   m0_addr, m1_addr, avl_addr;
  logic [15:0]   m0_be, m1_be, avl_be;
  logic          m0_burstbegin, m0_read_req, m0_write_req, m0_ready, m0_rdata_valid;
  logic          m1_burstbegin, m1_read_req, m1_write_req, m1_ready, m1_rdata_valid;
  logic [4:0]    m0_size, m1_size, avl_size;
  logic [127:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, avl_wdata, avl_rdata;
  logic          avl_burstbegin, avl_read_req, avl_write_req, avl_ready, avl_rdata_valid, rd_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit sb_id[$];

  mcpu_avl_arb dut (
    .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n),
    .m0_addr(m0_addr), .m0_be(m0_be), .m0_burstbegin(m0_burstbegin),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_addr(m1_addr), .m1_be(m1_be), .m1_burstbegin(m1_burstbegin),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .avl_addr(avl_addr), .avl_be(avl_be), .avl_burstbegin(avl_burstbegin),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .avl_wdata(avl_wdata), .avl_ready(avl_ready), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid), .rd_err(rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_masters();
    m0_addr = '0; m0_be = '0; m0_burstbegin = 0; m0_read_req = 0; m0_write_req = 0;
    m0_size = '0; m0_wdata = '0;
    m1_addr = '0; m1_be = '0; m1_burstbegin = 0; m1_read_req = 0; m1_write_req = 0;
    m1_size = '0; m1_wdata = '0;
  endtask

  // Drive one controller beat and compare routing against the scoreboard head (no clock advance).
  task automatic ret_check(input logic [127:0] d);
    bit id;
    avl_rdata_valid = 1'b1;
    avl_rdata       = d;
    #3;
    if (sb_id.size() == 0) begin
      check("ret_spurious_v0", m0_rdata_valid, 0);
      check("ret_spurious_v1", m1_rdata_valid, 0);
    end else begin
      id = sb_id.pop_front();
      check("ret_m0_valid", m0_rdata_valid, id == 1'b0);
      check("ret_m1_valid", m1_rdata_valid, id == 1'b1);
      check("ret_rdata", id ? m1_rdata : m0_rdata, d);
    end
  endtask

  task automatic ret_beat(input logic [127:0] d);
    ret_check(d);
    step();
    avl_rdata_valid = 1'b0;
    avl_rdata       = '0;
  endtask

  initial begin
    int  c0, c1, b;
    bit  prio, g, gap, stall;

    rst_n = 1'b0;
    zero_masters();
    avl_ready = 1'b1; avl_rdata = '0; avl_rdata_valid = 1'b0;
    #2;
    check("rst_avl_read", avl_read_req, 0);
    check("rst_avl_write", avl_write_req, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_rd_err", rd_err, 0);
    #10 rst_n = 1'b1;
    step();

    // Single read, size 4.
    m0_read_req = 1; m0_addr = 25'h100; m0_size = 5'd4; m0_burstbegin = 1; m0_be = '1;
    #3;
    check("t1_m0_ready", m0_ready, 1);
    check("t1_m1_ready", m1_ready, 0);
    check("t1_avl_read", avl_read_req, 1);
    check("t1_avl_addr", avl_addr, 25'h100);
    check("t1_avl_size", avl_size, 4);
    check("t1_avl_bb", avl_burstbegin, 1);
    repeat (4) sb_id.push_back(1'b0);
    step();
    zero_masters();
    for (int i = 0; i < 4; i++) ret_beat(128'hA000 + 128'(i));
    prio = 1'b1;

    // Contention: three back-to-back single-beat reads per master (m1 uses size 0 == 1 beat).
    c0 = 0; c1 = 0;
    for (int k = 0; k < 6; k++) begin
      m0_read_req = (c0 < 3); m0_addr = 25'h200 + 25'(c0); m0_size = 5'd1;
      m1_read_req = (c1 < 3); m1_addr = 25'h300 + 25'(c1); m1_size = 5'd0;
      g = (c0 < 3 && c1 < 3) ? prio : (c0 >= 3);
      #3;
      check("t2_m0_ready", m0_ready, g == 1'b0);
      check("t2_m1_ready", m1_ready, g == 1'b1);
      check("t2_avl_addr", avl_addr, g ? 25'h300 + 25'(c1) : 25'h200 + 25'(c0));
      sb_id.push_back(g);
      if (g) c1++; else c0++;
      prio = ~g;
      step();
    end
    zero_masters();
    for (int i = 0; i < 6; i++) ret_beat(128'hB000 + 128'(i));

    // Write burst lock: m1 writes 8 beats with a 2-cycle gap after beat 3; m0 read waits.
    b = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      gap = (cyc == 3 || cyc == 4);
      m1_write_req = !gap; m1_addr = 25'h400; m1_size = 5'd8; m1_be = '1;
      m1_burstbegin = (b == 0); m1_wdata = 128'hC0DE_0000 + 128'(b);
      if (cyc >= 1) begin m0_read_req = 1; m0_addr = 25'h500; m0_size = 5'd2; end
      #3;
      check("t3_m1_ready", m1_ready, !gap);
      check("t3_avl_write", avl_write_req, !gap);
      check("t3_m0_ready", m0_ready, 0);
      check("t3_avl_read", avl_read_req, 0);
      if (!gap) begin
        check("t3_avl_wdata", avl_wdata, 128'hC0DE_0000 + 128'(b));
        b++;
      end
      step();
    end
    m1_write_req = 0; m1_burstbegin = 0;
    #3;
    check("t3_m0_after", m0_ready, 1);
    check("t3_avl_addr", avl_addr, 25'h500);
    sb_id.push_back(1'b0); sb_id.push_back(1'b0);
    step();
    zero_masters();
    for (int i = 0; i < 2; i++) ret_beat(128'hD000 + 128'(i));

    // Backpressure: m0 4-beat write, controller stalls 5 cycles on beat 1; m1 read waits.
    b = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      stall = (cyc >= 1 && cyc <= 5);
      avl_ready = !stall;
      m0_write_req = 1; m0_addr = 25'h600; m0_size = 5'd4; m0_burstbegin = (b == 0);
      m0_wdata = 128'hE000_0000 + 128'(b);
      if (cyc >= 1) begin m1_read_req = 1; m1_addr = 25'h700; m1_size = 5'd1; end
      #3;
      check("t5_m0_ready", m0_ready, !stall);
      check("t5_avl_write", avl_write_req, 1);
      check("t5_avl_wdata", avl_wdata, 128'hE000_0000 + 128'(b));
      check("t5_m1_ready", m1_ready, 0);
      if (!stall) b++;
      step();
    end
    avl_ready = 1'b1;
    m0_write_req = 0; m0_burstbegin = 0;
    #3;
    check("t5_m1_after", m1_ready, 1);
    check("t5_avl_addr", avl_addr, 25'h700);
    sb_id.push_back(1'b1);
    step();
    zero_masters();
    ret_beat(128'hF00D);

    // FIFO full: eight single-beat m0 reads outstanding, ninth must wait.
    for (int k = 0; k < 8; k++) begin
      m0_read_req = 1; m0_addr = 25'h800 + 25'(k); m0_size = 5'd1;
      #3;
      check("t4_fill_ready", m0_ready, 1);
      sb_id.push_back(1'b0);
      step();
    end
    m0_addr = 25'h808;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin m1_read_req = 1; m1_addr = 25'h900; m1_size = 5'd1; end
      #3;
      check("t4_full_m0_ready", m0_ready, 0);
      check("t4_full_avl_read", avl_read_req, 0);
      check("t4_full_m1_ready", m1_ready, 0);
      step();
    end
    ret_check(128'h1234_5678);
    check("t4_nobypass_m0", m0_ready, 0);
    check("t4_nobypass_m1", m1_ready, 0);
    step();
    avl_rdata_valid = 1'b0; avl_rdata = '0;
    #3;
    check("t4_ninth_m0", m0_ready, 1);
    check("t4_ninth_m1", m1_ready, 0);
    check("t4_ninth_addr", avl_addr, 25'h808);
    sb_id.push_back(1'b0);
    step();
    m0_read_req = 0;
    #3;
    check("t4_refull_m1", m1_ready, 0);
    check("t4_refull_read", avl_read_req, 0);
    step();
    zero_masters();
    for (int i = 0; i < 8; i++) ret_beat(128'h5000 + 128'(i));

    // Spurious return with an empty FIFO sets sticky rd_err.
    ret_beat(128'hDEAD);
    #3;
    check("t6_rd_err_set", rd_err, 1);
    step(); step(); step();
    check("t6_rd_err_sticky", rd_err, 1);

    // Reset in the middle of a write burst.
    m1_write_req = 1; m1_addr = 25'hA00; m1_size = 5'd4; m1_burstbegin = 1; m1_wdata = 128'h77;
    #3;
    check("t6_burst_start", m1_ready, 1);
    step();
    m1_burstbegin = 0; m1_wdata = 128'h78;
    m0_read_req = 1; m0_addr = 25'hB00; m0_size = 5'd1;
    #1;
    check("t6_in_burst_m0", m0_ready, 0);
    rst_n = 1'b0;
    zero_masters();
    #1;
    check("t6_rst_rd_err", rd_err, 0);
    check("t6_rst_m0_ready", m0_ready, 0);
    check("t6_rst_m1_ready", m1_ready, 0);
    check("t6_rst_avl_write", avl_write_req, 0);
    check("t6_rst_avl_wdata", avl_wdata, 0);
    check("t6_rst_avl_addr", avl_addr, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    m0_read_req = 1; m0_addr = 25'hC00; m0_size = 5'd1;
    m1_read_req = 1; m1_addr = 25'hC10; m1_size = 5'd1;
    #3;
    check("t6_post_m0", m0_ready, 1);
    check("t6_post_m1", m1_ready, 0);
    sb_id.push_back(1'b0);
    step();
    m0_read_req = 0;
    #3;
    check("t6_post_m1_next", m1_ready, 1);
    sb_id.push_back(1'b1);
    step();
    zero_masters();
    ret_beat(128'hAAAA);
    ret_beat(128'hBBBB);
    check("t6_rd_err_clear", rd_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
